// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// FSM states and the bundle of pipeline stall/flush controls.
package hazard_pkg;

    // Operand source for an execute-stage ALU input.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,  // register file value read in decode
        FWD_W  = 2'b01,  // writeback-stage result
        FWD_M  = 2'b10   // memory-stage ALU result
    } fwd_sel_t;

    // Sequencing FSM for memory wait and branch redirect.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        REDIRECT = 2'b10
    } hz_state_t;

    // x0 is hardwired to zero and is never a real producer.
    localparam int REG_ZERO = 0;

    // Control lines into the fetch/decode/execute pipeline registers.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic flush_d;
        logic flush_e;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard
// controller (slave): register indices and qualifiers in, stall/flush,
// forwarding selects and statistics counters out.
interface hazard_ctrl_unit_if
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) ();

    logic [REG_ADDR_WIDTH-1:0] Rs1D_i;
    logic [REG_ADDR_WIDTH-1:0] Rs2D_i;
    logic [REG_ADDR_WIDTH-1:0] RdE_i;
    logic [REG_ADDR_WIDTH-1:0] RdM_i;
    logic [REG_ADDR_WIDTH-1:0] RdW_i;
    logic                      regWriteE_i;
    logic                      regWriteM_i;
    logic                      regWriteW_i;
    logic                      resultSrcE_i;
    logic                      PCSrcE_i;
    logic                      memBusyM_i;

    logic                      stallF_o;
    logic                      stallD_o;
    logic                      stallE_o;
    logic                      flushD_o;
    logic                      flushE_o;
    fwd_sel_t                  forwardAE_o;
    fwd_sel_t                  forwardBE_o;
    logic [CNT_WIDTH-1:0]      stallCount_o;
    logic [CNT_WIDTH-1:0]      flushCount_o;

    // Pipeline datapath side.
    modport master (
        output Rs1D_i, Rs2D_i, RdE_i, RdM_i, RdW_i,
        output regWriteE_i, regWriteM_i, regWriteW_i,
        output resultSrcE_i, PCSrcE_i, memBusyM_i,
        input  stallF_o, stallD_o, stallE_o, flushD_o, flushE_o,
        input  forwardAE_o, forwardBE_o, stallCount_o, flushCount_o
    );

    // Hazard controller side.
    modport slave (
        input  Rs1D_i, Rs2D_i, RdE_i, RdM_i, RdW_i,
        input  regWriteE_i, regWriteM_i, regWriteW_i,
        input  resultSrcE_i, PCSrcE_i, memBusyM_i,
        output stallF_o, stallD_o, stallE_o, flushD_o, flushE_o,
        output forwardAE_o, forwardBE_o, stallCount_o, flushCount_o
    );

endinterface

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter for hazard statistics: counts cycles with inc
// high and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next value: advance only while below the all-ones ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            // NOTE: state is written with <= so every register samples the
            // pre-edge values; = here would race against other flops.
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Drives stall/flush of the F/D/E pipeline registers, sequences memory
// wait and branch redirect with a small FSM, and keeps saturating
// stall/redirect statistics.
// Build option HAZARD_FWD_EN: when defined, execute operands are
// forwarded from M/W (tracked via an execute-stage shadow of rs1/rs2)
// and only load-use stalls. When undefined, forwarding selects are tied
// to the register file and any RAW against E/M/W stalls decode instead.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_unit_if.slave hz
);

    localparam logic [REG_ADDR_WIDTH-1:0] X0 = REG_ADDR_WIDTH'(REG_ZERO);

    // A writing stage with a real (non-x0) destination that matches rs.
    function automatic logic reg_hit(
        input logic                      we,
        input logic [REG_ADDR_WIDTH-1:0] rd,
        input logic [REG_ADDR_WIDTH-1:0] rs
    );
        return we && (rd != X0) && (rd == rs);
    endfunction

    hz_state_t state_q;
    hz_state_t state_d;
    hz_ctrl_t  ctrl;
    hz_ctrl_t  ctrl_out;
    logic      flush_inc;
    logic      load_use;
    logic      data_hazard;

    // Load in execute whose result decode needs next cycle.
    assign load_use = hz.resultSrcE_i && (hz.RdE_i != X0) &&
                      ((hz.RdE_i == hz.Rs1D_i) || (hz.RdE_i == hz.Rs2D_i));

`ifdef HAZARD_FWD_EN
    // With forwarding only the load result arrives too late to bypass.
    assign data_hazard = load_use;
`else
    // Without forwarding any pending write to a decode source must drain.
    // W is kept in the check even though the register file writes on the
    // opposite edge; the conservative stall costs little.
    assign data_hazard = load_use
        || reg_hit(hz.regWriteE_i, hz.RdE_i, hz.Rs1D_i)
        || reg_hit(hz.regWriteE_i, hz.RdE_i, hz.Rs2D_i)
        || reg_hit(hz.regWriteM_i, hz.RdM_i, hz.Rs1D_i)
        || reg_hit(hz.regWriteM_i, hz.RdM_i, hz.Rs2D_i)
        || reg_hit(hz.regWriteW_i, hz.RdW_i, hz.Rs1D_i)
        || reg_hit(hz.regWriteW_i, hz.RdW_i, hz.Rs2D_i);
`endif

    // Next state and pipeline controls; priority is mem busy, then
    // taken branch, then data hazard.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        ctrl      = '0;
        flush_inc = 1'b0;
        case (state_q)
            // MEM_WAIT releases by re-evaluating the RUN rules in the same
            // cycle, so a branch held during the wait redirects at once.
            RUN, MEM_WAIT: begin
                if (hz.memBusyM_i) begin
                    ctrl.stall_f = 1'b1;
                    ctrl.stall_d = 1'b1;
                    ctrl.stall_e = 1'b1;
                    state_d      = MEM_WAIT;
                end else if (hz.PCSrcE_i) begin
                    ctrl.flush_d = 1'b1;
                    ctrl.flush_e = 1'b1;
                    flush_inc    = 1'b1;
                    state_d      = REDIRECT;
                end else begin
                    state_d = RUN;
                    if (data_hazard) begin
                        ctrl.stall_f = 1'b1;
                        ctrl.stall_d = 1'b1;
                        ctrl.flush_e = 1'b1;
                    end
                end
            end
            // Execute holds the bubble from the redirect, so its branch
            // and load indications are stale and ignored.
            REDIRECT: begin
                if (hz.memBusyM_i) begin
                    ctrl.stall_f = 1'b1;
                    ctrl.stall_d = 1'b1;
                    ctrl.stall_e = 1'b1;
                    state_d      = MEM_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Keep the pipe free of stalls/flushes while reset is held, even if
    // memory reports busy.
    assign ctrl_out    = rst_n ? ctrl : '0;
    assign hz.stallF_o = ctrl_out.stall_f;
    assign hz.stallD_o = ctrl_out.stall_d;
    assign hz.stallE_o = ctrl_out.stall_e;
    assign hz.flushD_o = ctrl_out.flush_d;
    assign hz.flushE_o = ctrl_out.flush_e;

`ifdef HAZARD_FWD_EN
    logic [REG_ADDR_WIDTH-1:0] rs1_e_q;
    logic [REG_ADDR_WIDTH-1:0] rs2_e_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_e_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_e_d;
    fwd_sel_t                  fwd_a;
    fwd_sel_t                  fwd_b;

    // Shadow of execute sources follows the execute register: bubble on
    // flush, hold on stall, otherwise take what decode presents.
    always_comb begin
        rs1_e_d = hz.Rs1D_i;
        rs2_e_d = hz.Rs2D_i;
        if (ctrl.flush_e) begin
            rs1_e_d = X0;
            rs2_e_d = X0;
        end else if (ctrl.stall_e) begin
            rs1_e_d = rs1_e_q;
            rs2_e_d = rs2_e_q;
        end
    end

    // Shadow register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_e_q <= X0;
            rs2_e_q <= X0;
        end else begin
            rs1_e_q <= rs1_e_d;
            rs2_e_q <= rs2_e_d;
        end
    end

    // Forwarding selects; M is younger than W and wins.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (reg_hit(hz.regWriteM_i, hz.RdM_i, rs1_e_q)) begin
            fwd_a = FWD_M;
        end else if (reg_hit(hz.regWriteW_i, hz.RdW_i, rs1_e_q)) begin
            fwd_a = FWD_W;
        end
        if (reg_hit(hz.regWriteM_i, hz.RdM_i, rs2_e_q)) begin
            fwd_b = FWD_M;
        end else if (reg_hit(hz.regWriteW_i, hz.RdW_i, rs2_e_q)) begin
            fwd_b = FWD_W;
        end
    end

    assign hz.forwardAE_o = fwd_a;
    assign hz.forwardBE_o = fwd_b;
`else
    assign hz.forwardAE_o = FWD_RF;
    assign hz.forwardBE_o = FWD_RF;
`endif

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl.stall_d),
        .count (hz.stallCount_o)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (hz.flushCount_o)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with 4-bit counters so saturation
// is reachable. Expected values follow the HAZARD_FWD_EN setting.
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;

    localparam int AW = 5;
    localparam int CW = 4;

    // Control vector order: {stallF, stallD, stallE, flushD, flushE}.
    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_MEM   = 5'b11100;
    localparam logic [4:0] C_FLUSH = 5'b00011;
    localparam logic [4:0] C_LU    = 5'b11001;

`ifdef HAZARD_FWD_EN
    localparam logic [1:0] EXP_FM     = 2'b10;
    localparam logic [1:0] EXP_FW     = 2'b01;
    localparam logic [4:0] RAW_CTRL   = C_IDLE;
    localparam int         RAW_STALLS = 0;
`else
    localparam logic [1:0] EXP_FM     = 2'b00;
    localparam logic [1:0] EXP_FW     = 2'b00;
    localparam logic [4:0] RAW_CTRL   = C_LU;
    localparam int         RAW_STALLS = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   exp_stall;

    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) hz_if ();

    hazard_ctrl_unit #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_if.slave)
    );

    wire [4:0] ctrl_w = {hz_if.stallF_o, hz_if.stallD_o, hz_if.stallE_o,
                         hz_if.flushD_o, hz_if.flushE_o};

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        hz_if.Rs1D_i       = '0;
        hz_if.Rs2D_i       = '0;
        hz_if.RdE_i        = '0;
        hz_if.RdM_i        = '0;
        hz_if.RdW_i        = '0;
        hz_if.regWriteE_i  = 1'b0;
        hz_if.regWriteM_i  = 1'b0;
        hz_if.regWriteW_i  = 1'b0;
        hz_if.resultSrcE_i = 1'b0;
        hz_if.PCSrcE_i     = 1'b0;
        hz_if.memBusyM_i   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        #3;
        check("rst_ctrl", ctrl_w, C_IDLE);
        check("rst_fwdA", hz_if.forwardAE_o, 2'b00);
        check("rst_fwdB", hz_if.forwardBE_o, 2'b00);
        check("rst_scnt", hz_if.stallCount_o, 0);
        check("rst_fcnt", hz_if.flushCount_o, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset asserted in the middle of a memory wait.
        hz_if.memBusyM_i = 1'b1;
        #1 check("mw_ctrl1", ctrl_w, C_MEM);
        tick();
        check("mw_ctrl2", ctrl_w, C_MEM);
        check("mw_scnt", hz_if.stallCount_o, 1);
        rst_n = 1'b0;
        #1 check("rst_async_ctrl", ctrl_w, C_IDLE);
        check("rst_async_scnt", hz_if.stallCount_o, 0);
        tick();
        check("rst_hold_ctrl", ctrl_w, C_IDLE);
        set_idle();
        rst_n = 1'b1;
        #1 check("post_rst_ctrl", ctrl_w, C_IDLE);
        tick();
        check("post_rst_scnt", hz_if.stallCount_o, 0);

        // Load-use on rs1.
        hz_if.resultSrcE_i = 1'b1;
        hz_if.regWriteE_i  = 1'b1;
        hz_if.RdE_i        = 5'd5;
        hz_if.Rs1D_i       = 5'd5;
        #1 check("lu_ctrl", ctrl_w, C_LU);
        tick();
        check("lu_scnt", hz_if.stallCount_o, 1);
        // Dependent enters execute with rs1=5, load moves to M.
        set_idle();
        hz_if.Rs1D_i = 5'd5;
        #1 check("lu_cap_ctrl", ctrl_w, C_IDLE);
        tick();
        set_idle();
        hz_if.RdM_i       = 5'd5;
        hz_if.regWriteM_i = 1'b1;
        #1 check("lu_fwdA_m", hz_if.forwardAE_o, EXP_FM);
        check("lu_fwd_ctrl", ctrl_w, C_IDLE);
        tick();

        // Forward priority M over W, then W alone and x0 exclusion.
        set_idle();
        hz_if.Rs1D_i = 5'd7;
        hz_if.Rs2D_i = 5'd7;
        #1 check("f1_ctrl", ctrl_w, C_IDLE);
        tick();
        set_idle();
        hz_if.RdM_i       = 5'd7;
        hz_if.regWriteM_i = 1'b1;
        hz_if.RdW_i       = 5'd7;
        hz_if.regWriteW_i = 1'b1;
        hz_if.Rs1D_i      = 5'd9;
        #1 check("fwd_prio_b", hz_if.forwardBE_o, EXP_FM);
        check("fwd_prio_a", hz_if.forwardAE_o, EXP_FM);
        check("f2_ctrl", ctrl_w, C_IDLE);
        tick();
        set_idle();
        hz_if.RdM_i       = 5'd0;
        hz_if.regWriteM_i = 1'b1;
        hz_if.RdW_i       = 5'd9;
        hz_if.regWriteW_i = 1'b1;
        #1 check("fwd_w_a", hz_if.forwardAE_o, EXP_FW);
        check("fwd_x0_b", hz_if.forwardBE_o, 2'b00);
        check("f3_ctrl", ctrl_w, C_IDLE);
        tick();

        // Taken branch together with load-use: flush only.
        set_idle();
        hz_if.PCSrcE_i     = 1'b1;
        hz_if.resultSrcE_i = 1'b1;
        hz_if.regWriteE_i  = 1'b1;
        hz_if.RdE_i        = 5'd6;
        hz_if.Rs2D_i       = 5'd6;
        #1 check("br_lu_ctrl", ctrl_w, C_FLUSH);
        check("br_lu_fcnt0", hz_if.flushCount_o, 0);
        tick();
        // REDIRECT ignores branch and load-use.
        check("redir_fcnt", hz_if.flushCount_o, 1);
        check("redir_ctrl", ctrl_w, C_IDLE);
        check("redir_scnt", hz_if.stallCount_o, 1);
        tick();
        check("redir_fcnt2", hz_if.flushCount_o, 1);
        // Memory busy during REDIRECT still forces a wait.
        set_idle();
        hz_if.PCSrcE_i = 1'b1;
        #1 check("br2_ctrl", ctrl_w, C_FLUSH);
        tick();
        set_idle();
        hz_if.memBusyM_i = 1'b1;
        #1 check("redir_mem_ctrl", ctrl_w, C_MEM);
        check("redir_mem_fcnt", hz_if.flushCount_o, 2);
        tick();
        set_idle();
        #1 check("mw_exit_ctrl", ctrl_w, C_IDLE);
        check("mw_exit_scnt", hz_if.stallCount_o, 2);
        tick();

        // Branch held in execute through a 4-cycle memory wait.
        hz_if.PCSrcE_i   = 1'b1;
        hz_if.memBusyM_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("mwb_ctrl", ctrl_w, C_MEM);
            tick();
        end
        check("mwb_scnt", hz_if.stallCount_o, 6);
        hz_if.memBusyM_i = 1'b0;
        #1 check("mwb_release", ctrl_w, C_FLUSH);
        tick();
        check("mwb_fcnt", hz_if.flushCount_o, 3);
        set_idle();
        #1 check("mwb_redir_ctrl", ctrl_w, C_IDLE);
        tick();

        // RAW against W, E and M: stalls only without forwarding.
        exp_stall = 6;
        hz_if.RdW_i       = 5'd3;
        hz_if.regWriteW_i = 1'b1;
        hz_if.Rs1D_i      = 5'd3;
        #1 check("raw_w_ctrl", ctrl_w, RAW_CTRL);
        check("raw_w_fwdA", hz_if.forwardAE_o, 2'b00);
        tick();
        exp_stall += RAW_STALLS;
        set_idle();
        hz_if.RdE_i       = 5'd4;
        hz_if.regWriteE_i = 1'b1;
        hz_if.Rs2D_i      = 5'd4;
        #1 check("raw_e_ctrl", ctrl_w, RAW_CTRL);
        tick();
        exp_stall += RAW_STALLS;
        set_idle();
        hz_if.RdM_i       = 5'd8;
        hz_if.regWriteM_i = 1'b1;
        hz_if.Rs1D_i      = 5'd8;
        #1 check("raw_m_ctrl", ctrl_w, RAW_CTRL);
        tick();
        exp_stall += RAW_STALLS;
        set_idle();
        hz_if.RdM_i  = 5'd8;
        hz_if.Rs1D_i = 5'd8;
        #1 check("raw_nowe_ctrl", ctrl_w, C_IDLE);
        tick();
        check("raw_scnt", hz_if.stallCount_o, 16'(exp_stall));

`ifdef HAZARD_FWD_EN
        // Shadow holds its value while execute is stalled.
        set_idle();
        hz_if.Rs1D_i = 5'd7;
        tick();
        hz_if.memBusyM_i = 1'b1;
        hz_if.Rs1D_i     = 5'd8;
        tick();
        set_idle();
        hz_if.RdM_i       = 5'd7;
        hz_if.regWriteM_i = 1'b1;
        #1 check("shadow_hold_fwdA", hz_if.forwardAE_o, 2'b10);
        tick();
`endif

        // Flush counter saturation: branch held high, one flush per
        // RUN/REDIRECT pair.
        set_idle();
        hz_if.PCSrcE_i = 1'b1;
        repeat (30) tick();
        check("fcnt_sat", hz_if.flushCount_o, 15);
        set_idle();
        tick();

        // Stall counter saturation over 20 wait cycles.
        hz_if.memBusyM_i = 1'b1;
        repeat (20) tick();
        check("sat_stall_ctrl", ctrl_w, C_MEM);
        check("scnt_sat", hz_if.stallCount_o, 15);
        hz_if.memBusyM_i = 1'b0;
        #1 check("sat_exit_ctrl", ctrl_w, C_IDLE);
        tick();
        check("scnt_sat_hold", hz_if.stallCount_o, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
